gps_ca_codegen: RTL and testbench
=================================

# gps_ca_codegen

Generates the GPS L1 C/A Gold code (1023-chip, 1 ms period) for a selectable PRN 1–32. It sits directly downstream of the GPS clock generator and runs on its 10.23 MHz fast clock. An internal divide-by-CHIP_DIV chip enable yields the 1.023 Mchip/s rate, so no second clock domain is needed. It feeds chips, chip strobes and epoch markers to the P-code/correlator and test-pattern stages.

## Interface
Parameters:
- CHIP_DIV, 10, fast-clock cycles per chip; legal range 2..1023.

Ports:
- gps_clk_fast  input  1  sole clock, 10.23 MHz.
- gps_rst  input  1  synchronous, active-high reset.
- sv_num  input  6  PRN select; sampled only on an accepted code_start; legal range 1..32.
- code_start  input  1  single-cycle start/restart request.
- code_stop  input  1  single-cycle stop request.
- ca_chip  output  1  current C/A chip value.
- chip_valid  output  1  one-cycle strobe marking a new chip on ca_chip.
- chip_index  output  10  index of current chip, 0..1022.
- epoch  output  1  one-cycle strobe coincident with chip_valid when chip_index==0.
- code_busy  output  1  high while in RUN.
- cfg_err  output  1  one-cycle pulse on a start with illegal sv_num.

One clock; reset is synchronous and active-high.

## Operation
- G1 LFSR, 10 bits, polynomial 1+x^3+x^10; output is G1[10]. G2 LFSR, 10 bits, polynomial 1+x^2+x^3+x^6+x^8+x^9+x^10. Both are loaded to all-ones on start.
- Chip = G1[10] XOR G2[a] XOR G2[b], with the tap pair (a,b) indexed by PRN:
  - PRN 1–9: (2,6)(3,7)(4,8)(5,9)(1,9)(2,10)(1,8)(2,9)(3,10).
  - PRN 10–18: (2,3)(3,4)(5,6)(6,7)(7,8)(8,9)(9,10)(1,4)(2,5).
  - PRN 19–27: (3,6)(4,7)(5,8)(6,9)(1,3)(4,6)(5,7)(6,8)(7,9).
  - PRN 28–32: (8,10)(1,6)(2,7)(3,8)(4,9).
- Tap pair is latched at start; later sv_num changes have no effect until the next start.
- FSM states are IDLE and RUN.
  - IDLE + code_start with legal sv_num: load LFSRs, set div_cnt=0 and chip_index=0, go to RUN.
  - IDLE + code_start with illegal sv_num (0 or 33..63): pulse cfg_err, stay in IDLE.
  - RUN + code_start with legal sv_num: restart identically to a start from IDLE.
  - RUN + code_start with illegal sv_num: pulse cfg_err, go to IDLE.
  - RUN + code_stop (no start): go to IDLE.
  - code_start and code_stop asserted together: code_start wins.
  - code_stop in IDLE: ignored.
- div_cnt counts 0..CHIP_DIV-1 and wraps. When div_cnt==CHIP_DIV-1, both LFSRs shift once and chip_index increments. chip_index wraps 1022→0, and both LFSRs return to all-ones naturally at that wrap.
- Entering IDLE clears ca_chip, chip_valid, epoch, code_busy and chip_index to 0.

## Timing
- Reset: every output is 0; state is IDLE; LFSRs are all-ones; div_cnt=0. Reset has priority over all inputs, including mid-RUN.
- All outputs are registered.
- If code_start is accepted in cycle T:
  - T+1: code_busy=1, chip_valid=1, epoch=1, chip_index=0, ca_chip=chip 0.
  - chip k is presented at T+1+k·CHIP_DIV with a one-cycle chip_valid.
  - ca_chip and chip_index hold between strobes.
- epoch repeats every 1023·CHIP_DIV cycles (10230 at default).
- cfg_err asserts in cycle T+1 when the start is rejected.
- code_stop sampled in cycle T: at T+1, code_busy=0 and all outputs are 0.
- A restart during RUN discards the current div_cnt phase. The new chip 0 appears at T+1 with no gap or extra strobe.

## Test plan
- Reset, then sv_num=1 with code_start → first 10 chips are 1,1,0,0,1,0,0,0,0,0 (octal 1440); epoch asserts with chip 0 only; strobes are spaced 10 cycles apart.
- sv_num=2 start → first 10 chips are 1,1,1,0,0,1,0,0,0,0 (octal 1620).
- Run PRN 7 for 2046 chips, then:
  - exactly 512 ones per period;
  - epoch at chips 0 and 1023, 10230 cycles apart;
  - chip_index wraps 1022→0;
  - second period bit-identical to the first.
- code_start with sv_num=0, then with sv_num=33 → cfg_err pulses at T+1; code_busy stays 0; no chip_valid.
- Mid-RUN (chip 500):
  - code_start with sv_num=2 → next cycle chip_index=0, epoch=1, PRN 2 sequence.
  - Separately, code_start and code_stop in the same cycle → restart.
- Assert gps_rst at chip 300 → next cycle all outputs are 0 and state is IDLE. A subsequent start reproduces chip 0 exactly; CHIP_DIV=2 build shows strobes every 2 cycles.

Source files
------------

// File: rtl/gps_ca_codegen.sv
// GPS L1 C/A Gold-code generator: G1/G2 LFSR pair with PRN-selected G2 taps.
// Runs on the 10.23 MHz fast clock and derives the chip rate from an internal divider.
module gps_ca_codegen #(
    parameter int CHIP_DIV = 10
) (
    input  logic       gps_clk_fast,
    input  logic       gps_rst,
    input  logic [5:0] sv_num,
    input  logic       code_start,
    input  logic       code_stop,
    output logic       ca_chip,
    output logic       chip_valid,
    output logic [9:0] chip_index,
    output logic       epoch,
    output logic       code_busy,
    output logic       cfg_err
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [9:0]  DIV_LAST  = 10'(CHIP_DIV - 1);
    localparam logic [9:0]  LAST_CHIP = 10'd1022;
    localparam logic [10:1] LFSR_ONES = '1;

    // G2 phase-selector tap pair {a, b} for each PRN; zero for illegal PRNs.
    function automatic logic [7:0] prn_taps(input logic [5:0] prn);
        case (prn)
            6'd1:    return {4'd2, 4'd6};
            6'd2:    return {4'd3, 4'd7};
            6'd3:    return {4'd4, 4'd8};
            6'd4:    return {4'd5, 4'd9};
            6'd5:    return {4'd1, 4'd9};
            6'd6:    return {4'd2, 4'd10};
            6'd7:    return {4'd1, 4'd8};
            6'd8:    return {4'd2, 4'd9};
            6'd9:    return {4'd3, 4'd10};
            6'd10:   return {4'd2, 4'd3};
            6'd11:   return {4'd3, 4'd4};
            6'd12:   return {4'd5, 4'd6};
            6'd13:   return {4'd6, 4'd7};
            6'd14:   return {4'd7, 4'd8};
            6'd15:   return {4'd8, 4'd9};
            6'd16:   return {4'd9, 4'd10};
            6'd17:   return {4'd1, 4'd4};
            6'd18:   return {4'd2, 4'd5};
            6'd19:   return {4'd3, 4'd6};
            6'd20:   return {4'd4, 4'd7};
            6'd21:   return {4'd5, 4'd8};
            6'd22:   return {4'd6, 4'd9};
            6'd23:   return {4'd1, 4'd3};
            6'd24:   return {4'd4, 4'd6};
            6'd25:   return {4'd5, 4'd7};
            6'd26:   return {4'd6, 4'd8};
            6'd27:   return {4'd7, 4'd9};
            6'd28:   return {4'd8, 4'd10};
            6'd29:   return {4'd1, 4'd6};
            6'd30:   return {4'd2, 4'd7};
            6'd31:   return {4'd3, 4'd8};
            6'd32:   return {4'd4, 4'd9};
            default: return 8'h00;
        endcase
    endfunction

    // Stage numbers run 1..10, so pad both ends and index directly.
    function automatic logic g2_stage(input logic [10:1] g2, input logic [3:0] idx);
        logic [15:0] ext;
        ext = {5'b0, g2, 1'b0};
        return ext[idx];
    endfunction

    function automatic logic [10:1] g1_step(input logic [10:1] g1);
        return {g1[9:1], g1[3] ^ g1[10]};
    endfunction

    function automatic logic [10:1] g2_step(input logic [10:1] g2);
        return {g2[9:1], g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10]};
    endfunction

    function automatic logic chip_of(input logic [10:1] g1, input logic [10:1] g2,
                                     input logic [3:0] tap_a, input logic [3:0] tap_b);
        return g1[10] ^ g2_stage(g2, tap_a) ^ g2_stage(g2, tap_b);
    endfunction

    state_t      state_q, state_d;
    logic [10:1] g1_q, g1_d;
    logic [10:1] g2_q, g2_d;
    logic [9:0]  div_cnt_q, div_cnt_d;
    logic [9:0]  chip_index_q, chip_index_d;
    logic [3:0]  tap_a_q, tap_a_d;
    logic [3:0]  tap_b_q, tap_b_d;
    logic        ca_chip_q, ca_chip_d;
    logic        chip_valid_q, chip_valid_d;
    logic        epoch_q, epoch_d;
    logic        code_busy_q, code_busy_d;
    logic        cfg_err_q, cfg_err_d;

    logic        sv_legal;
    logic [7:0]  start_taps;
    logic [10:1] g1_next;
    logic [10:1] g2_next;

    assign sv_legal   = (sv_num >= 6'd1) && (sv_num <= 6'd32);
    assign start_taps = prn_taps(sv_num);
    assign g1_next    = g1_step(g1_q);
    assign g2_next    = g2_step(g2_q);

    // NOTE: every signal driven here gets a default first, so no path can infer a latch.
    always_comb begin
        state_d      = state_q;
        g1_d         = g1_q;
        g2_d         = g2_q;
        div_cnt_d    = div_cnt_q;
        chip_index_d = chip_index_q;
        tap_a_d      = tap_a_q;
        tap_b_d      = tap_b_q;
        ca_chip_d    = ca_chip_q;
        chip_valid_d = 1'b0;
        epoch_d      = 1'b0;
        code_busy_d  = code_busy_q;
        cfg_err_d    = 1'b0;

        if (code_start) begin
            if (sv_legal) begin
                // A restart drops the old divider phase; chip 0 is presented next cycle.
                state_d      = RUN;
                g1_d         = LFSR_ONES;
                g2_d         = LFSR_ONES;
                div_cnt_d    = '0;
                chip_index_d = '0;
                tap_a_d      = start_taps[7:4];
                tap_b_d      = start_taps[3:0];
                ca_chip_d    = chip_of(LFSR_ONES, LFSR_ONES, start_taps[7:4], start_taps[3:0]);
                chip_valid_d = 1'b1;
                epoch_d      = 1'b1;
                code_busy_d  = 1'b1;
            end else begin
                state_d      = IDLE;
                cfg_err_d    = 1'b1;
                div_cnt_d    = '0;
                chip_index_d = '0;
                ca_chip_d    = 1'b0;
                code_busy_d  = 1'b0;
            end
        end else if (state_q == RUN) begin
            if (code_stop) begin
                state_d      = IDLE;
                div_cnt_d    = '0;
                chip_index_d = '0;
                ca_chip_d    = 1'b0;
                code_busy_d  = 1'b0;
            end else if (div_cnt_q == DIV_LAST) begin
                // Both registers are maximal-length, so they are all-ones again at the 1022->0 wrap.
                div_cnt_d    = '0;
                g1_d         = g1_next;
                g2_d         = g2_next;
                chip_index_d = (chip_index_q == LAST_CHIP) ? 10'd0 : chip_index_q + 10'd1;
                ca_chip_d    = chip_of(g1_next, g2_next, tap_a_q, tap_b_q);
                chip_valid_d = 1'b1;
                epoch_d      = (chip_index_q == LAST_CHIP);
            end else begin
                div_cnt_d    = div_cnt_q + 10'd1;
            end
        end
    end

    // NOTE: state is updated with non-blocking assignments so all flops sample the same pre-edge values.
    always_ff @(posedge gps_clk_fast) begin
        if (gps_rst) begin
            state_q      <= IDLE;
            g1_q         <= LFSR_ONES;
            g2_q         <= LFSR_ONES;
            div_cnt_q    <= '0;
            chip_index_q <= '0;
            tap_a_q      <= '0;
            tap_b_q      <= '0;
            ca_chip_q    <= 1'b0;
            chip_valid_q <= 1'b0;
            epoch_q      <= 1'b0;
            code_busy_q  <= 1'b0;
            cfg_err_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            g1_q         <= g1_d;
            g2_q         <= g2_d;
            div_cnt_q    <= div_cnt_d;
            chip_index_q <= chip_index_d;
            tap_a_q      <= tap_a_d;
            tap_b_q      <= tap_b_d;
            ca_chip_q    <= ca_chip_d;
            chip_valid_q <= chip_valid_d;
            epoch_q      <= epoch_d;
            code_busy_q  <= code_busy_d;
            cfg_err_q    <= cfg_err_d;
        end
    end

    assign ca_chip    = ca_chip_q;
    assign chip_valid = chip_valid_q;
    assign chip_index = chip_index_q;
    assign epoch      = epoch_q;
    assign code_busy  = code_busy_q;
    assign cfg_err    = cfg_err_q;

endmodule

// File: tb/tb_gps_ca_codegen.sv
// Directed self-checking bench for gps_ca_codegen (default CHIP_DIV=10 plus a CHIP_DIV=2 instance).
// Expected chips come from constants in the test plan and an independent array-based Gold-code model.
module tb_gps_ca_codegen;

    localparam int D = 10;

    logic       clk = 1'b0;
    logic       gps_rst = 1'b1;
    logic [5:0] sv_num = '0;
    logic       code_start = 1'b0;
    logic       code_stop = 1'b0;
    logic       ca_chip, chip_valid, epoch, code_busy, cfg_err;
    logic [9:0] chip_index;

    logic [5:0] sv_num_2 = '0;
    logic       code_start_2 = 1'b0;
    logic       code_stop_2 = 1'b0;
    logic       ca_chip_2, chip_valid_2, epoch_2, code_busy_2, cfg_err_2;
    logic [9:0] chip_index_2;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic ref_chips [0:1022];
    logic obs_chips [0:2045];
    int   obs_idx   [0:2045];
    int   epoch_cyc [$];

    int tab_a [32] = '{2,3,4,5,1,2,1,2,3,2,3,5,6,7,8,9,1,2,3,4,5,6,1,4,5,6,7,8,1,2,3,4};
    int tab_b [32] = '{6,7,8,9,9,10,8,9,10,3,4,6,7,8,9,10,4,5,6,7,8,9,3,6,7,8,9,10,6,7,8,9};

    gps_ca_codegen #(.CHIP_DIV(D)) dut (
        .gps_clk_fast(clk), .gps_rst(gps_rst), .sv_num(sv_num),
        .code_start(code_start), .code_stop(code_stop),
        .ca_chip(ca_chip), .chip_valid(chip_valid), .chip_index(chip_index),
        .epoch(epoch), .code_busy(code_busy), .cfg_err(cfg_err)
    );

    gps_ca_codegen #(.CHIP_DIV(2)) dut2 (
        .gps_clk_fast(clk), .gps_rst(gps_rst), .sv_num(sv_num_2),
        .code_start(code_start_2), .code_stop(code_stop_2),
        .ca_chip(ca_chip_2), .chip_valid(chip_valid_2), .chip_index(chip_index_2),
        .epoch(epoch_2), .code_busy(code_busy_2), .cfg_err(cfg_err_2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference Gold code built from explicit shift-register arrays.
    task automatic build_ref(input int prn);
        int g1 [1:10];
        int g2 [1:10];
        int a, b, f1, f2;
        a = tab_a[prn-1];
        b = tab_b[prn-1];
        for (int i = 1; i <= 10; i++) begin
            g1[i] = 1;
            g2[i] = 1;
        end
        for (int k = 0; k < 1023; k++) begin
            ref_chips[k] = logic'(g1[10] ^ g2[a] ^ g2[b]);
            f1 = g1[3] ^ g1[10];
            f2 = g2[2] ^ g2[3] ^ g2[6] ^ g2[8] ^ g2[9] ^ g2[10];
            for (int i = 10; i >= 2; i--) begin
                g1[i] = g1[i-1];
                g2[i] = g2[i-1];
            end
            g1[1] = f1;
            g2[1] = f2;
        end
    endtask

    // Called at a negedge; after return the T+1 outputs are visible.
    task automatic pulse_start(input logic [5:0] sv, input logic with_stop);
        sv_num     = sv;
        code_start = 1'b1;
        code_stop  = with_stop;
        @(negedge clk);
        code_start = 1'b0;
        code_stop  = 1'b0;
    endtask

    // Entered on the negedge showing chip first_k; returns on the negedge showing the last chip.
    task automatic verify_chips(input int first_k, input int n, input string tag);
        int  idx;
        logic held;
        for (int i = 0; i < n; i++) begin
            idx = (first_k + i) % 1023;
            if (i < 2046) begin
                obs_chips[i] = ca_chip;
                obs_idx[i]   = int'(chip_index);
            end
            if (epoch === 1'b1) epoch_cyc.push_back(cyc);
            checks++;
            if (chip_valid !== 1'b1) begin
                errors++;
                $display("FAIL %s valid k=%0d got=%b exp=1", tag, first_k + i, chip_valid);
            end
            checks++;
            if (chip_index !== 10'(idx)) begin
                errors++;
                $display("FAIL %s index k=%0d got=%0d exp=%0d", tag, first_k + i, chip_index, idx);
            end
            checks++;
            if (epoch !== (idx == 0)) begin
                errors++;
                $display("FAIL %s epoch k=%0d got=%b exp=%b", tag, first_k + i, epoch, idx == 0);
            end
            checks++;
            if (ca_chip !== ref_chips[idx]) begin
                errors++;
                $display("FAIL %s chip k=%0d got=%b exp=%b", tag, first_k + i, ca_chip, ref_chips[idx]);
            end
            if (i != n - 1) begin
                held = ca_chip;
                for (int j = 1; j < D; j++) begin
                    @(negedge clk);
                    checks++;
                    if (chip_valid !== 1'b0 || epoch !== 1'b0 || ca_chip !== held || chip_index !== 10'(idx)) begin
                        errors++;
                        $display("FAIL %s gap k=%0d j=%0d got valid=%b epoch=%b chip=%b idx=%0d exp 0/0/%b/%0d",
                                 tag, first_k + i, j, chip_valid, epoch, ca_chip, chip_index, held, idx);
                    end
                end
                @(negedge clk);
            end
        end
    endtask

    task automatic check_all_zero(input string tag);
        checks++;
        if ({ca_chip, chip_valid, chip_index, epoch, code_busy, cfg_err} !== 15'd0) begin
            errors++;
            $display("FAIL %s outputs got chip=%b valid=%b idx=%0d epoch=%b busy=%b err=%b exp all 0",
                     tag, ca_chip, chip_valid, chip_index, epoch, code_busy, cfg_err);
        end
    endtask

    task automatic test_reset();
        gps_rst = 1'b1;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        checks++;
        if ({ca_chip_2, chip_valid_2, chip_index_2, epoch_2, code_busy_2, cfg_err_2} !== 15'd0) begin
            errors++;
            $display("FAIL reset_div2 outputs got nonzero exp all 0");
        end
        gps_rst = 1'b0;
        @(negedge clk);
        check_all_zero("reset_release");
    endtask

    task automatic test_prn_prefix();
        logic [9:0] exp_p1;
        logic [9:0] exp_p2;
        logic [9:0] got;
        exp_p1 = 10'o1440;
        exp_p2 = 10'o1620;
        build_ref(1);
        pulse_start(6'd1, 1'b0);
        checks++;
        if (code_busy !== 1'b1) begin
            errors++;
            $display("FAIL prn1 busy got=%b exp=1", code_busy);
        end
        verify_chips(0, 10, "prn1");
        for (int i = 0; i < 10; i++) got[9-i] = obs_chips[i];
        checks++;
        if (got !== exp_p1) begin
            errors++;
            $display("FAIL prn1 prefix got=%o exp=%o", got, exp_p1);
        end
        @(negedge clk);
        build_ref(2);
        pulse_start(6'd2, 1'b0);
        sv_num = 6'd5;
        verify_chips(0, 10, "prn2");
        for (int i = 0; i < 10; i++) got[9-i] = obs_chips[i];
        checks++;
        if (got !== exp_p2) begin
            errors++;
            $display("FAIL prn2 prefix got=%o exp=%o", got, exp_p2);
        end
    endtask

    task automatic test_long_prn7();
        int ones;
        int diffs;
        @(negedge clk);
        build_ref(7);
        epoch_cyc.delete();
        pulse_start(6'd7, 1'b0);
        verify_chips(0, 2046, "prn7");
        ones = 0;
        diffs = 0;
        for (int k = 0; k < 1023; k++) begin
            if (obs_chips[k] === 1'b1) ones++;
            if (obs_chips[k] !== obs_chips[k + 1023]) diffs++;
        end
        checks++;
        if (ones != 512) begin
            errors++;
            $display("FAIL prn7 ones got=%0d exp=512", ones);
        end
        checks++;
        if (diffs != 0) begin
            errors++;
            $display("FAIL prn7 period_repeat got=%0d differing exp=0", diffs);
        end
        checks++;
        if (obs_idx[1022] != 1022 || obs_idx[1023] != 0) begin
            errors++;
            $display("FAIL prn7 wrap got=%0d->%0d exp=1022->0", obs_idx[1022], obs_idx[1023]);
        end
        checks++;
        if (epoch_cyc.size() != 2) begin
            errors++;
            $display("FAIL prn7 epoch_count got=%0d exp=2", epoch_cyc.size());
        end else begin
            checks++;
            if (epoch_cyc[1] - epoch_cyc[0] != 1023 * D) begin
                errors++;
                $display("FAIL prn7 epoch_spacing got=%0d exp=%0d", epoch_cyc[1] - epoch_cyc[0], 1023 * D);
            end
        end
    endtask

    task automatic test_stop();
        code_stop = 1'b1;
        @(negedge clk);
        code_stop = 1'b0;
        check_all_zero("stop");
        code_stop = 1'b1;
        @(negedge clk);
        code_stop = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check_all_zero("stop_idle");
        end
    endtask

    task automatic test_cfg_err();
        logic [5:0] bad [2];
        bad[0] = 6'd0;
        bad[1] = 6'd33;
        for (int i = 0; i < 2; i++) begin
            pulse_start(bad[i], 1'b0);
            checks++;
            if (cfg_err !== 1'b1 || code_busy !== 1'b0 || chip_valid !== 1'b0) begin
                errors++;
                $display("FAIL cfg_err sv=%0d got err=%b busy=%b valid=%b exp 1/0/0",
                         bad[i], cfg_err, code_busy, chip_valid);
            end
            repeat (12) begin
                @(negedge clk);
                check_all_zero("cfg_err_after");
            end
        end
        // Illegal restart while running drops back to IDLE.
        build_ref(3);
        pulse_start(6'd3, 1'b0);
        verify_chips(0, 3, "prn3");
        pulse_start(6'd63, 1'b0);
        checks++;
        if (cfg_err !== 1'b1 || code_busy !== 1'b0 || chip_valid !== 1'b0 || chip_index !== 10'd0) begin
            errors++;
            $display("FAIL cfg_err_run got err=%b busy=%b valid=%b idx=%0d exp 1/0/0/0",
                     cfg_err, code_busy, chip_valid, chip_index);
        end
        repeat (12) begin
            @(negedge clk);
            check_all_zero("cfg_err_run_after");
        end
    endtask

    task automatic test_back_to_back();
        build_ref(7);
        pulse_start(6'd7, 1'b0);
        verify_chips(0, 501, "pre_restart");
        repeat (3) @(negedge clk);
        build_ref(2);
        pulse_start(6'd2, 1'b0);
        verify_chips(0, 12, "restart_prn2");
        repeat (4) @(negedge clk);
        build_ref(1);
        pulse_start(6'd1, 1'b1);
        verify_chips(0, 12, "start_stop_prn1");
    endtask

    task automatic test_reset_mid_run();
        @(negedge clk);
        build_ref(9);
        pulse_start(6'd9, 1'b0);
        verify_chips(0, 301, "pre_reset");
        gps_rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_reset");
        gps_rst = 1'b0;
        repeat (12) begin
            @(negedge clk);
            check_all_zero("mid_reset_idle");
        end
        pulse_start(6'd9, 1'b0);
        verify_chips(0, 6, "post_reset");
    endtask

    task automatic test_chip_div2();
        build_ref(1);
        @(negedge clk);
        sv_num_2     = 6'd1;
        code_start_2 = 1'b1;
        @(negedge clk);
        code_start_2 = 1'b0;
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (chip_valid_2 !== 1'b1 || chip_index_2 !== 10'(k) || ca_chip_2 !== ref_chips[k]
                || epoch_2 !== (k == 0) || code_busy_2 !== 1'b1) begin
                errors++;
                $display("FAIL div2 chip k=%0d got valid=%b idx=%0d chip=%b epoch=%b exp 1/%0d/%b/%b",
                         k, chip_valid_2, chip_index_2, ca_chip_2, epoch_2, k, ref_chips[k], k == 0);
            end
            @(negedge clk);
            checks++;
            if (chip_valid_2 !== 1'b0) begin
                errors++;
                $display("FAIL div2 gap k=%0d got valid=%b exp=0", k, chip_valid_2);
            end
            @(negedge clk);
        end
        code_stop_2 = 1'b1;
        @(negedge clk);
        code_stop_2 = 1'b0;
        checks++;
        if (code_busy_2 !== 1'b0 || chip_valid_2 !== 1'b0) begin
            errors++;
            $display("FAIL div2 stop got busy=%b valid=%b exp 0/0", code_busy_2, chip_valid_2);
        end
    endtask

    initial begin
        test_reset();
        @(negedge clk);
        test_prn_prefix();
        test_long_prn7();
        test_stop();
        test_cfg_err();
        test_back_to_back();
        test_stop();
        test_reset_mid_run();
        test_chip_div2();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
